// File: rtl/packer_pkg.sv
// Shared types and widths for the FIFO word packer.
// Holds the FSM state enum, default geometry and width helpers.
package packer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_OUT
  } state_t;

  localparam int unsigned DEF_BYTE_WIDTH     = 8;
  localparam int unsigned DEF_WORD_BYTES     = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

  function automatic int unsigned pend_w(input int unsigned wb);
    return $clog2(wb + 1);
  endfunction

  function automatic int unsigned tcnt_w(input int unsigned tc);
    return $clog2(tc + 1);
  endfunction

  localparam int unsigned PEND_W = pend_w(DEF_WORD_BYTES);
  localparam int unsigned TCNT_W = tcnt_w(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/packer_timeout_cnt.sv
// Idle counter that drops a stale partial word.
// Ports: clk, reset (async, active-low), clear, pop, active
//        (idle with bytes pending), expire (comb), timeout (pulse).
module packer_timeout_cnt
  import packer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = TCNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic pop,
  input  logic active,
  output logic expire,
  output logic timeout
);

  logic [CNT_W-1:0] cnt_q;
  logic             hit;

  // The cycle that would take the count to TIMEOUT_CYCLES
  // is the last idle cycle; the drop lands on its edge.
  assign hit    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign expire = active && hit && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      if (clear || pop || expire) begin
        cnt_q <= '0;
      end else if (active) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from the RX FIFO and packs them little-endian into words.
// Ports: clk, reset (async, active-low), clear, fifo_empty/fifo_read/
//   fifo_read_data (pop side), word_valid/word_ready/word_data (push
//   side), bytes_pending, busy, timeout.
// Optional: define PACKER_TIMEOUT_EN to drop stale partial words.
module fifo_word_packer
  import packer_pkg::*;
#(
  parameter int unsigned BYTE_WIDTH     = DEF_BYTE_WIDTH,
  parameter int unsigned WORD_BYTES     = DEF_WORD_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               fifo_empty,
  output logic                               fifo_read,
  input  logic [BYTE_WIDTH-1:0]              fifo_read_data,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic [WORD_BYTES*BYTE_WIDTH-1:0]   word_data,
  output logic [pend_w(WORD_BYTES)-1:0]      bytes_pending,
  output logic                               busy,
  output logic                               timeout
);

  localparam int unsigned PW = pend_w(WORD_BYTES);
  localparam int unsigned DW = WORD_BYTES * BYTE_WIDTH;

  if (WORD_BYTES < 2 || WORD_BYTES > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("fifo_word_packer: unsupported WORD_BYTES or TIMEOUT_CYCLES");
  end

  state_t        state_q, state_d;
  logic [PW-1:0] pend_q, pend_d, pend_inc;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q;
  logic          last;
  logic          capture;
  logic          accept;
  logic          expire;
  logic          drop;

  assign pend_inc = pend_q + PW'(1);
  assign last     = (pend_inc == PW'(WORD_BYTES));
  assign capture  = (state_q == S_WAIT) && !clear;
  assign accept   = (state_q == S_OUT) && word_ready && !clear;
  assign drop     = clear || accept || expire;

  always_comb begin
    state_d   = state_q;
    fifo_read = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        fifo_read = !fifo_empty;
        if (!fifo_empty) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (last) state_d = S_OUT;
        else if (!fifo_empty) fifo_read = 1'b1;
        else state_d = S_IDLE;
      end
      S_OUT: begin
        if (word_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d   = S_IDLE;
      fifo_read = 1'b0;
    end
    // No pop may escape while reset is held.
    if (!reset) fifo_read = 1'b0;
  end

  // capture and drop are exclusive: expire only fires in S_IDLE.
  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    unique case (1'b1)
      capture: begin
        pend_d = pend_inc;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
          if (pend_q == PW'(i)) begin
            data_d[i*BYTE_WIDTH +: BYTE_WIDTH] = fifo_read_data;
          end
        end
      end
      drop:    pend_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      valid_q <= (state_d == S_OUT);
    end
  end

`ifdef PACKER_TIMEOUT_EN
  packer_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (tcnt_w(TIMEOUT_CYCLES))
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .pop    (fifo_read),
    .active ((state_q == S_IDLE) && (pend_q != '0)),
    .expire (expire),
    .timeout(timeout)
  );
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign word_valid    = valid_q;
  assign word_data     = data_q;
  assign bytes_pending = pend_q;
  assign busy          = (state_q != S_IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: FIFO model, word table, corner sequences.
// Words are scored against a queue of expected values.
module tb_fifo_word_packer;

  localparam int WB  = 4;
  localparam int TMO = 16;
  localparam int PW  = $clog2(WB + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          fifo_empty;
  logic          fifo_read;
  logic [7:0]    fifo_read_data = 8'h00;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic [31:0]   word_data;
  logic [PW-1:0] bytes_pending;
  logic          busy;
  logic          timeout;

  logic [7:0]  mem [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          empty_reads = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          carry = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          push_rows;
    int          delay;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [4];

  fifo_word_packer #(
    .BYTE_WIDTH(8), .WORD_BYTES(WB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .fifo_read_data(fifo_read_data),
    .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .bytes_pending(bytes_pending),
    .busy(busy), .timeout(timeout)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_read) begin
      if (fifo_empty) begin
        empty_reads <= empty_reads + 1;
      end else begin
        fifo_read_data <= mem[rd_ptr[7:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic push4(input vec_t v);
    push(v.b0); push(v.b1); push(v.b2); push(v.b3);
  endtask

  task automatic run_word(input int delay, input bit lat_chk,
                          input string tag);
    int c_r, held, rp0;
    bit done;
    logic [31:0] e;
    c_r = (carry != 0) ? -1 : -100;
    carry = 0; held = 0; rp0 = rd_ptr; done = 0;
    word_ready = (delay == 0);
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (c_r == -100 && fifo_read) c_r = c;
      if (word_valid) begin
        if (held == 0) begin
          rp0 = rd_ptr;
          if (lat_chk) check({tag, "_latency"}, 64'(c - c_r), WB + 1);
        end
        if (held >= delay) begin
          if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 1, 0);
          end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, word_data, e);
          end
          if (delay > 0) check({tag, "_hold_pops"}, 64'(rd_ptr - rp0), 0);
          word_ready = 1'b1;
          @(negedge clk);
          check({tag, "_valid_drop"}, word_valid, 0);
          check({tag, "_pend_zero"}, bytes_pending, 0);
          carry = fifo_read ? 1 : 0;
          word_ready = 1'b0;
          done = 1;
        end else begin
          word_ready = 1'b0;
        end
        held++;
      end
    end
    if (!done) check({tag, "_no_word"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int found, nr, vseen, start, first, pulses;
    logic [PW-1:0] p17, p18;

    vt[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 1, 0,  32'h44332211};
    vt[1] = '{8'h01, 8'h02, 8'h03, 8'h04, 2, 10, 32'h04030201};
    vt[2] = '{8'h05, 8'h06, 8'h07, 8'h08, 0, 0,  32'h08070605};
    vt[3] = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 1, 3,  32'h00FF5AA5};

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", word_valid, 0);
    check("rst_data", word_data, 0);
    check("rst_pend", bytes_pending, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    push(8'h99);
    #1 check("rst_no_pop", fifo_read, 0);
    wr_ptr = rd_ptr;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      for (int r = i; r < i + vt[i].push_rows; r++) begin
        push4(vt[r]);
        exp_q.push_back(vt[r].exp);
      end
      if (vt[i].push_rows > 0) carry = 1;
      run_word(vt[i].delay, 1'b1, $sformatf("row%0d", i));
    end

    push(8'hAA); push(8'hBB);
    repeat (4) @(negedge clk);
    nr = 0; vseen = 0;
    repeat (50) begin
      @(negedge clk);
      if (fifo_read) nr++;
      if (word_valid) vseen = 1;
    end
    check("gap_pend", bytes_pending, 2);
    check("gap_reads", nr, 0);
    check("gap_valid", vseen, 0);
    check("gap_busy", busy, 1);
    push(8'hCC); push(8'hDD);
    exp_q.push_back(32'hDDCCBBAA);
    run_word(0, 1'b0, "gap");

    start = wr_ptr;
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (bytes_pending == PW'(3)) found = 1;
    end
    check("clr_reach3", found, 1);
    clear = 1'b1;
    #1 check("clr_wait_read", fifo_read, 0);
    @(negedge clk);
    clear = 1'b0;
    check("clr_pend", bytes_pending, 0);
    check("clr_valid", word_valid, 0);
    check("clr_consumed", 64'(rd_ptr - start), 4);
    vseen = 0;
    repeat (5) begin
      @(negedge clk);
      if (word_valid) vseen = 1;
    end
    check("clr_no_partial", vseen, 0);
    clear = 1'b1;
    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    #1 check("clr_idle_read", fifo_read, 0);
    @(negedge clk);
    clear = 1'b0;
    exp_q.push_back(32'h13121110);
    run_word(0, 1'b0, "clr");

    push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
    repeat (2) @(negedge clk);
    check("arst_pre_pend", bytes_pending, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_mid_pend", bytes_pending, 0);
    check("arst_mid_data", word_data, 0);
    check("arst_mid_busy", busy, 0);
    check("arst_mid_read", fifo_read, 0);
    wr_ptr = rd_ptr;
    @(negedge clk);
    reset = 1'b1;

    word_ready = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk);
      if (word_valid) found = 1;
    end
    check("arst_out_reach", found, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", word_valid, 0);
    check("arst_out_data", word_data, 0);
    check("arst_out_pend", bytes_pending, 0);
    check("arst_out_read", fifo_read, 0);
    wr_ptr = rd_ptr;
    @(negedge clk);
    reset = 1'b1;

    push(8'h5A);
    first = -1; pulses = 0; p17 = '0; p18 = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (timeout) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (k == 17) p17 = bytes_pending;
      if (k == 18) p18 = bytes_pending;
    end
`ifdef PACKER_TIMEOUT_EN
    check("tmo_when", 64'(first), 18);
    check("tmo_pulses", pulses, 1);
    check("tmo_pend_before", p17, 1);
    check("tmo_pend_after", p18, 0);
    check("tmo_busy", busy, 0);
`else
    check("tmo_off_pulses", pulses, 0);
    check("tmo_off_pend_17", p17, 1);
    check("tmo_off_pend", p18, 1);
`endif
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    check("no_read_when_empty", empty_reads, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the byte FIFO that sits between the UART receive path and the command interpreter.
- Pops bytes from the FIFO through its read/empty interface; the popped byte is registered and valid the cycle after `read`.
- Assembles WORD_BYTES bytes little-endian into one word and hands the word to the interpreter over a valid/ready handshake.
- Also supports a synchronous clear and reports partial-word progress.

Parameters:
- BYTE_WIDTH, 8, width of one FIFO entry.
- WORD_BYTES, 4, bytes per assembled word; legal range 2..8.
- TIMEOUT_CYCLES, 1000000, idle cycles before a partial word is discarded; used only with PACKER_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset); asserts asynchronously, releases synchronously to clk.
- clear  input  1  synchronous flush of the partial word and of any held word.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read  output  1  FIFO pop strobe.
- fifo_read_data  input  BYTE_WIDTH  FIFO output; valid the cycle after fifo_read.
- word_valid  output  1  assembled word available.
- word_ready  input  1  consumer accepts the word.
- word_data  output  WORD_BYTES*BYTE_WIDTH  assembled word.
- bytes_pending  output  clog2(WORD_BYTES+1)  bytes accumulated so far.
- busy  output  1  high when state != S_IDLE or bytes_pending != 0.
- timeout  output  1  one-cycle pulse when a partial word is dropped.

Behaviour:
- Reset values: state S_IDLE, word_data 0, bytes_pending 0, word_valid 0, timeout 0. fifo_read is 0 during reset.
- FSM has three states:
  - S_IDLE: fifo_read = !fifo_empty. If fifo_read, go to S_WAIT; otherwise stay.
  - S_WAIT: fifo_read_data is valid this cycle. Write it into lane bytes_pending, i.e. word_data[bytes_pending*BYTE_WIDTH +: BYTE_WIDTH], so the first byte lands in bits [BYTE_WIDTH-1:0]. Increment bytes_pending.
    - If the new count == WORD_BYTES: fifo_read = 0, go to S_OUT.
    - Else if !fifo_empty: fifo_read = 1 (back-to-back pop), stay in S_WAIT.
    - Else: go to S_IDLE.
  - S_OUT: word_valid = 1, and word_data is held stable. fifo_read = 0. When word_ready = 1: bytes_pending <= 0, word_valid drops the next cycle, go to S_IDLE.
- fifo_read is combinational from state, fifo_empty and clear. It is never high while fifo_empty = 1.
- Throughput: a full word with the FIFO never empty takes WORD_BYTES+1 cycles from the first fifo_read to word_valid.
- word_valid is registered. Once raised it stays high until accepted or cleared, and word_data must not change while it is high.
- word_ready while word_valid = 0 is ignored.
- Unused upper lanes keep their previous contents. Stale bytes are fully overwritten before the next word_valid.
- clear = 1:
  - fifo_read is forced to 0 that cycle.
  - Next state is S_IDLE, bytes_pending 0, word_valid 0, word_data unchanged.
  - A byte in flight in S_WAIT is discarded, consuming one FIFO entry.
  - clear has priority over word_ready and over the timeout.
- Reset mid-operation aborts immediately with no pop. Bytes already popped are lost.
- An empty FIFO mid-word does not error; the block waits in S_IDLE with bytes_pending held.

Optional Feature:
- Macro: PACKER_TIMEOUT_EN.
- Defined:
  - An idle counter of width clog2(TIMEOUT_CYCLES+1) increments each cycle in S_IDLE with bytes_pending != 0.
  - It resets to 0 on any pop, clear or reset.
  - When it reaches TIMEOUT_CYCLES: bytes_pending <= 0, counter <= 0, and timeout pulses high for exactly one cycle.
  - A pop requested in that same cycle still proceeds, and that byte becomes lane 0 of a new word.
- Undefined: no counter is built, timeout is tied to 0, and partial words wait indefinitely.

Decomposition:
- Package packer_pkg holds:
  - the state enum {S_IDLE, S_WAIT, S_OUT};
  - the localparams for the bytes_pending and timeout-counter widths;
  - the default BYTE_WIDTH and WORD_BYTES.
- One sub-module, packer_timeout_cnt: counter, compare and pulse logic. It is instantiated only under PACKER_TIMEOUT_EN.

Test Plan:
- Reset, then preload FIFO with 0x11,0x22,0x33,0x44 while word_ready = 1 → fifo_read high 4 consecutive cycles, word_data = 0x44332211, word_valid high 1 cycle, bytes_pending returns to 0.
- 8 bytes 0x01..0x08 preloaded, word_ready = 0 for 10 cycles → word_valid held with 0x04030201 and no pops during the hold. After ready, second word = 0x08070605.
- Feed 0xAA,0xBB then FIFO empty for 50 cycles, then 0xCC,0xDD → bytes_pending holds 2, no fifo_read while empty, final word = 0xDDCCBBAA.
- Assert clear in S_WAIT after 3 bytes, then feed 0x10..0x13 → in-flight byte dropped, word_valid never high for the partial word, next word = 0x13121110.
- Drive reset low asynchronously (between clock edges) mid-word, and also while word_valid = 1 → all outputs go to reset values without a clock edge, and fifo_read = 0.
- With PACKER_TIMEOUT_EN and TIMEOUT_CYCLES = 16: one byte 0x5A, then idle → timeout pulses exactly 1 cycle, 16 idle cycles after the capture; bytes_pending = 0. Without the macro, timeout stays 0.
